// File: rtl/shift_pkg.sv
// Shared opcode and FSM encodings for the mARC shift execution unit.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/right_shifter.sv
// Combinational logical right barrel shifter: log2(width) stages of power-of-two shifts.
module right_shifter #(
  parameter int width = 16,
  localparam int l = $clog2(width)
) (
  input  logic [width-1:0] a,
  input  logic [l-1:0]     amount,
  output logic [width-1:0] y
);

  logic [width-1:0] stage;

  always_comb begin
    stage = a;
    for (int i = 0; i < l; i++) begin
      if (amount[i]) stage = stage >> (1 << i);
    end
    y = stage;
  end

endmodule

// File: rtl/shift_unit.sv
// Sequential shift unit: accept request, one EXEC cycle through right_shifter, hold result.
// Optional macro SHIFT_SRA_EN enables the arithmetic right shift on op 10.
module shift_unit
  import shift_pkg::*;
#(
  parameter int width = 16,
  localparam int l = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [width-1:0] a,
  input  logic [l-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] y,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             err,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.

  state_t state, state_nxt;

  logic [width-1:0] a_r;
  logic [l-1:0]     b_r;
  logic [1:0]       op_r;

  logic [width-1:0] rev_a, sh_in, sh_y, res_y, carry_src;
  logic             res_err, res_c;

  function automatic logic [width-1:0] bit_rev(input logic [width-1:0] v);
    logic [width-1:0] r;
    for (int i = 0; i < width; i++) r[i] = v[width-1-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_EXEC;
      ST_EXEC:                state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      op_r <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      a_r  <= a;
      b_r  <= b;
      op_r <= op;
    end
  end

  // Left shifts reuse the right shifter by reversing the operand on the way in and out.
  assign rev_a = bit_rev(a_r);
  assign sh_in = (op_r == OP_SLL) ? rev_a : a_r;

  right_shifter #(.width(width)) u_right_shifter (
    .a      (sh_in),
    .amount (b_r),
    .y      (sh_y)
  );

  always_comb begin
    res_y     = a_r;
    res_err   = 1'b0;
    carry_src = a_r;
    case (op_r)
      OP_SLL: begin
        res_y     = bit_rev(sh_y);
        carry_src = rev_a;
      end
      OP_SRL: res_y = sh_y;
`ifdef SHIFT_SRA_EN
      OP_SRA: res_y = sh_y | (a_r[width-1] ? ~({width{1'b1}} >> b_r) : '0);
`endif
      default: begin
        res_y   = a_r;
        res_err = 1'b1;
      end
    endcase
    // Last bit shifted out; rev_a[b-1] is a[width-b] for left shifts.
    res_c = (!res_err && b_r != '0) ? carry_src[b_r - l'(1)] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y   <= '0;
      n   <= 1'b0;
      z   <= 1'b0;
      c   <= 1'b0;
      err <= 1'b0;
    end else if (state == ST_EXEC) begin
      y   <= res_y;
      n   <= res_y[width-1];
      z   <= (res_y == '0);
      c   <= res_c;
      err <= res_err;
    end
  end

endmodule
